// File: rtl/fir_tap_buffer.sv
// fir_tap_buffer
//   Unpacks a stream of 32-bit H words (two 16-bit taps per word) into a
//   bank of NB_TAPS coefficient registers and presents them in parallel to
//   the FIR MAC datapath. A one-cycle done_o pulse marks the last tap write.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear (same effect as reset)
//   start_i         one-cycle pulse, arms a new tap load
//   h_valid_i       H stream valid
//   h_ready_o       H stream ready (high only while loading)
//   h_data_i        H word: [15:0] even tap, [31:16] odd tap
//   done_o          one-cycle pulse after the last word is accepted
//   taps_valid_o    high while the bank holds a complete tap set
//   taps_o          flat tap bank, slice i = tap i
//
// Build option
//   FIR_TAP_BUFFER_REVERSE_EN: present the bank time-reversed
//   (slice i = tap[NB_TAPS-1-i]); storage and handshake are unchanged.

module fir_tap_buffer #(
  parameter int unsigned NB_TAPS   = 50,
  parameter int unsigned TAP_WIDTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic                           h_valid_i,
  output logic                           h_ready_o,
  input  logic [31:0]                    h_data_i,
  output logic                           done_o,
  output logic                           taps_valid_o,
  output logic [NB_TAPS*TAP_WIDTH-1:0]   taps_o
);

  localparam int unsigned NB_WORDS = (NB_TAPS + 1) / 2;
  localparam int unsigned CNT_W    = $clog2(NB_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [TAP_WIDTH-1:0] taps_q [NB_TAPS];
  logic [TAP_WIDTH-1:0] taps_d [NB_TAPS];

  logic accept;
  logic last_word;

  // Ready is blocked in the start/clear cycle so a beat there is never taken.
  assign h_ready_o = (state_q == LOAD) & ~start_i & ~clear_i;
  assign accept    = h_valid_i & h_ready_o;
  assign last_word = (cnt_q == CNT_W'(NB_WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (start_i) begin
      state_d = LOAD;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_word) begin
        state_d = FULL;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  // Word k owns taps 2k and 2k+1; for odd NB_TAPS the last word has no
  // odd slot, so its upper half simply matches no register.
  always_comb begin
    taps_d = taps_q;
    if (clear_i) begin
      for (int unsigned i = 0; i < NB_TAPS; i++) begin
        taps_d[i] = '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < NB_TAPS; i++) begin
        if (CNT_W'(i / 2) == cnt_q) begin
          taps_d[i] = (i % 2 == 0) ? h_data_i[TAP_WIDTH-1:0]
                                   : h_data_i[2*TAP_WIDTH-1:TAP_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NB_TAPS; i++) begin
        taps_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      taps_q  <= taps_d;
    end
  end

  assign done_o       = done_q;
  assign taps_valid_o = valid_q;

  for (genvar g = 0; g < NB_TAPS; g++) begin : g_out
`ifdef FIR_TAP_BUFFER_REVERSE_EN
    assign taps_o[g*TAP_WIDTH +: TAP_WIDTH] = taps_q[NB_TAPS-1-g];
`else
    assign taps_o[g*TAP_WIDTH +: TAP_WIDTH] = taps_q[g];
`endif
  end

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Testbench for fir_tap_buffer: two instances (NB_TAPS=4 and NB_TAPS=5)
// share one input stream; a spec-level model of each is checked every
// cycle, and literal expectations pin the model at key points.

module tb_fir_tap_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic        h_valid;
  logic [31:0] h_data;

  logic        ready4, done4, tvalid4;
  logic [63:0] taps4;
  logic        ready5, done5, tvalid5;
  logic [79:0] taps5;

  int checks   = 0;
  int failures = 0;
  int dcnt4    = 0;
  int dcnt5    = 0;

  fir_tap_buffer #(.NB_TAPS(4), .TAP_WIDTH(16)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .h_valid_i(h_valid), .h_ready_o(ready4), .h_data_i(h_data),
    .done_o(done4), .taps_valid_o(tvalid4), .taps_o(taps4)
  );

  fir_tap_buffer #(.NB_TAPS(5), .TAP_WIDTH(16)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .h_valid_i(h_valid), .h_ready_o(ready5), .h_data_i(h_data),
    .done_o(done5), .taps_valid_o(tvalid5), .taps_o(taps5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected flat bank for a 4-tap set given in storage order.
  function automatic logic [63:0] exp4(input logic [15:0] t0, t1, t2, t3);
`ifdef FIR_TAP_BUFFER_REVERSE_EN
    return {t0, t1, t2, t3};
`else
    return {t3, t2, t1, t0};
`endif
  endfunction

  function automatic logic [79:0] exp5(input logic [15:0] t0, t1, t2, t3, t4);
`ifdef FIR_TAP_BUFFER_REVERSE_EN
    return {t0, t1, t2, t3, t4};
`else
    return {t4, t3, t2, t1, t0};
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 full
  int          ntaps [2] = '{4, 5};
  int          m_mode[2];
  int          m_k   [2];
  logic [15:0] m_tap [2][5];
  logic        m_done[2];
  logic        m_valid[2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || clear) begin
        m_mode[d]  <= 0;
        m_k[d]     <= 0;
        m_done[d]  <= 1'b0;
        m_valid[d] <= 1'b0;
        for (int i = 0; i < 5; i++) m_tap[d][i] <= 16'h0;
      end else begin
        m_done[d] <= 1'b0;
        if (start) begin
          m_mode[d]  <= 1;
          m_k[d]     <= 0;
          m_valid[d] <= 1'b0;
        end else if (h_valid && m_mode[d] == 1) begin
          m_tap[d][2*m_k[d]] <= h_data[15:0];
          if (2*m_k[d] + 1 < ntaps[d]) m_tap[d][2*m_k[d]+1] <= h_data[31:16];
          m_k[d] <= m_k[d] + 1;
          if (m_k[d] + 1 == (ntaps[d] + 1) / 2) begin
            m_mode[d]  <= 2;
            m_done[d]  <= 1'b1;
            m_valid[d] <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare, mid-cycle with inputs stable.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [79:0] e;
      logic        er;
      e = '0;
      for (int i = 0; i < ntaps[d]; i++) begin
`ifdef FIR_TAP_BUFFER_REVERSE_EN
        e[i*16 +: 16] = m_tap[d][ntaps[d]-1-i];
`else
        e[i*16 +: 16] = m_tap[d][i];
`endif
      end
      er = (m_mode[d] == 1) && !start && !clear;
      check($sformatf("ready_n%0d", ntaps[d]), {79'h0, (d == 0) ? ready4 : ready5}, {79'h0, er});
      check($sformatf("done_n%0d", ntaps[d]), {79'h0, (d == 0) ? done4 : done5}, {79'h0, m_done[d]});
      check($sformatf("tvalid_n%0d", ntaps[d]), {79'h0, (d == 0) ? tvalid4 : tvalid5}, {79'h0, m_valid[d]});
      check($sformatf("taps_n%0d", ntaps[d]), (d == 0) ? {16'h0, taps4} : taps5, e);
    end
    if (done4) dcnt4++;
    if (done5) dcnt5++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; h_valid = 1'b0; h_data = '0;
    step(2);
    check("reset_taps4", {16'h0, taps4}, 80'h0);
    check("reset_ready4", {79'h0, ready4}, 80'h0);
    check("reset_tvalid5", {79'h0, tvalid5}, 80'h0);
    rst_n = 1'b1;
    step(1);

    // Back-to-back beats; third beat completes the 5-tap set and stalls the 4-tap one.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0002_0001; step(1);
    h_data = 32'h0004_0003; step(1);
    h_data = 32'hBEEF_0005; step(1);
    h_valid = 1'b0; step(2);
    check("t1_taps4", {16'h0, taps4}, {16'h0, exp4(16'h1, 16'h2, 16'h3, 16'h4)});
    check("t1_taps5", taps5, exp5(16'h1, 16'h2, 16'h3, 16'h4, 16'h5));
    check("t1_done4_count", 80'(dcnt4), 80'd1);
    check("t1_done5_count", 80'(dcnt5), 80'd1);
    check("t1_ready4_full", {79'h0, ready4}, 80'h0);

    // Valid with a gap: only two accepts for the 4-tap instance.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0012_0011; step(1);
    h_valid = 1'b0; h_data = 32'hDEAD_BEEF; step(2);
    h_valid = 1'b1; h_data = 32'h0014_0013; step(1);
    h_valid = 1'b0; step(2);
    check("t3_taps4", {16'h0, taps4}, {16'h0, exp4(16'h11, 16'h12, 16'h13, 16'h14)});
    check("t3_done4_count", 80'(dcnt4), 80'd2);
    check("t3_tvalid5", {79'h0, tvalid5}, 80'h0);

    // Restart mid-load.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0002_0001; step(1);
    start = 1'b1; h_data = 32'hDEAD_DEAD; step(1);
    start = 1'b0; h_data = 32'h0006_0005; step(1);
    h_data = 32'h0008_0007; step(1);
    h_valid = 1'b0; step(2);
    check("t4_taps4", {16'h0, taps4}, {16'h0, exp4(16'h5, 16'h6, 16'h7, 16'h8)});
    check("t4_done4_count", 80'(dcnt4), 80'd3);

    // Soft clear after the first word.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0032_0031; step(1);
    h_valid = 1'b0; clear = 1'b1; step(1);
    clear = 1'b0; step(2);
    check("t5_clear_taps4", {16'h0, taps4}, 80'h0);
    check("t5_clear_tvalid4", {79'h0, tvalid4}, 80'h0);
    check("t5_clear_ready4", {79'h0, ready4}, 80'h0);
    check("t5_done4_count", 80'(dcnt4), 80'd3);

    // Asynchronous reset during a load, away from any clock edge.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0042_0041; step(1);
    h_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_areset_taps4", {16'h0, taps4}, 80'h0);
    check("t6_areset_taps5", taps5, 80'h0);
    check("t6_areset_ready4", {79'h0, ready4}, 80'h0);
    rst_n = 1'b1;
    step(2);
    check("t6_done4_count", 80'(dcnt4), 80'd3);

    // start_i coincident with the last beat: no accept, no done.
    pulse_start();
    h_valid = 1'b1; h_data = 32'h0052_0051; step(1);
    start = 1'b1; h_data = 32'h0054_0053; step(1);
    start = 1'b0; h_valid = 1'b0; step(2);
    check("t7_done4_count", 80'(dcnt4), 80'd3);
    check("t7_tvalid4", {79'h0, tvalid4}, 80'h0);

    // Fresh full load recovers normally.
    h_valid = 1'b1; h_data = 32'h0022_0021; step(1);
    h_data = 32'h0024_0023; step(1);
    h_valid = 1'b0; step(2);
    check("t8_taps4", {16'h0, taps4}, {16'h0, exp4(16'h21, 16'h22, 16'h23, 16'h24)});
    check("t8_done4_count", 80'(dcnt4), 80'd4);
    check("t8_tvalid4", {79'h0, tvalid4}, 80'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_buffer.md
Name: fir_tap_buffer

Overview:
- Sits between the H-stream source/serializer and the FIR datapath.
- Consumes 32-bit H words, each holding two 16-bit taps, and unpacks them into a register bank of NB_TAPS coefficients.
- Exposes all taps in parallel to the MAC datapath.
- Raises a one-cycle done flag, which the controller uses to move from tap loading to compute.

Parameters:
- NB_TAPS, 50, number of 16-bit filter taps stored (>=1, odd allowed).
- TAP_WIDTH, 16, bits per tap (fixed at 16; two taps per 32-bit word).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear (from slave clear).
- start_i  in  1  one-cycle pulse; arms a new tap load.
- h_valid_i  in  1  H stream valid.
- h_ready_o  out  1  H stream ready.
- h_data_i  in  32  H stream data; [15:0] = even tap, [31:16] = odd tap.
- done_o  out  1  one-cycle pulse when the last tap is written.
- taps_valid_o  out  1  level; high while the bank holds a complete tap set.
- taps_o  out  NB_TAPS*16  flat tap bank; slice i = tap i (signed 16-bit).

Behaviour:
- Derived constant: NB_WORDS = ceil(NB_TAPS/2). The word counter is $clog2(NB_WORDS+1) bits wide.
- States:
  - IDLE: reset state.
  - LOAD
  - FULL
- Reset (rst_ni=0): state IDLE, word counter 0, all taps 0, h_ready_o=0, done_o=0, taps_valid_o=0.
- clear_i=1: same effect as reset on the next edge. clear_i has priority over start_i and over a handshake.
- start_i=1 in any state: next state LOAD, counter 0, taps_valid_o 0. Tap contents are retained, not zeroed.
- h_ready_o = (state==LOAD) & ~start_i & ~clear_i. This is combinational, so a beat presented in the start_i cycle is not accepted.
- Handshake: a beat is accepted when h_valid_i & h_ready_o on a rising edge. h_ready_o must not depend on h_valid_i.
- On accept of word k:
  - tap[2k] <= h_data_i[15:0]
  - tap[2k+1] <= h_data_i[31:16], only if 2k+1 < NB_TAPS; otherwise the upper half is discarded.
  - counter increments.
- Last word (k == NB_WORDS-1) accepted:
  - next state FULL;
  - done_o=1 in the following cycle only, registered, no combinational path from h_valid_i;
  - taps_valid_o=1 from that same cycle.
- FULL: h_ready_o=0. Further H beats stall indefinitely and are never absorbed. Taps are held stable until start_i or clear_i.
- IDLE: h_ready_o=0, taps_valid_o=0.
- Throughput: one word per cycle. A full load takes NB_WORDS accepted beats; done_o follows the last accept by 1 cycle.
- Latency: taps_o reflects a written word 1 cycle after its accept.
- Reset or clear mid-LOAD: load is aborted, taps are zeroed, done_o is never pulsed.
- start_i mid-LOAD: load restarts from word 0, and partially written taps are overwritten by the new load.
- start_i in the same cycle as the last-word accept: the beat is not accepted (ready is low) and no done_o pulse occurs.
- taps_o is a pure function of the tap registers (no combinational input path).

Optional Feature:
- Macro: FIR_TAP_BUFFER_REVERSE_EN.
- Defined: the bank is presented time-reversed, i.e. taps_o slice i = tap[NB_TAPS-1-i]. Storage order and handshake are unchanged, so the datapath can index x[n-i] with slice i directly.
- Undefined: slice i = tap[i].

Test Plan:
- NB_TAPS=4; start_i; beats 0x0002_0001, 0x0004_0003 back-to-back.
  - Response: taps_o = {4,3,2,1} (slice0=1); done_o pulses exactly once 1 cycle after the 2nd accept; h_ready_o=0 afterwards.
- NB_TAPS=5; three beats 0x0002_0001, 0x0004_0003, 0xBEEF_0005.
  - Response: slice4=5; 0xBEEF discarded; done_o after the 3rd accept.
- NB_TAPS=4; h_valid_i toggled 1,0,1 with a gap.
  - Response: exactly 2 accepts; done_o 1 cycle after the second; no accept while h_valid_i=0.
- Mid-load: after 1 of 2 words, assert start_i, then send 0x0006_0005, 0x0008_0007.
  - Response: taps = 5,6,7,8; single done_o pulse.
- clear_i after the first word; reset asserted asynchronously during LOAD.
  - Response: taps all 0, taps_valid_o=0, state IDLE, no done_o pulse.
- FIR_TAP_BUFFER_REVERSE_EN defined, NB_TAPS=4, same beats as the first test.
  - Response: slice0=4, slice3=1.
